// File: rtl/replay_seq_arbiter.sv
// -----------------------------------------------------------------------------
// replay_seq_arbiter
//
// Lets N requester streams share one replay buffer. The buffer input is granted
// to one requester for a whole sequence of LEN items, so items from different
// sequences never interleave. Requesters are picked round-robin. The ID of each
// granted sequence goes into a small tag FIFO. The FIFO is popped when the
// buffer output handshake shows the last item of the last repetition. This
// lets downstream logic see which requester owns the data currently replaying.
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset (reset the buffer in the same cycle)
//   idat      requester data, requester k in bits [k*W +: W]
//   ivld      per-requester valid
//   irdy      per-requester ready (only the granted requester can see ready)
//   bdat      data to buffer input
//   bvld      valid to buffer input
//   brdy      ready from buffer input
//   mfin      tap of buffer ofin (final item of final repetition)
//   mvld      tap of buffer ovld
//   mrdy      tap of downstream ready on the buffer output
//   otag      requester ID of the sequence at the buffer output
//   otag_vld  otag is meaningful (tag FIFO non-empty)
// -----------------------------------------------------------------------------
module replay_seq_arbiter #(
    parameter int N    = 4,
    parameter int LEN  = 16,
    parameter int W    = 8,
    parameter int TAGS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N*W-1:0]            idat,
    input  logic [N-1:0]              ivld,
    output logic [N-1:0]              irdy,
    output logic [W-1:0]              bdat,
    output logic                      bvld,
    input  logic                      brdy,
    input  logic                      mfin,
    input  logic                      mvld,
    input  logic                      mrdy,
    output logic [$clog2(N)-1:0]      otag,
    output logic                      otag_vld
);

    localparam int IDW = $clog2(N);
    localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int PW  = (TAGS > 1) ? $clog2(TAGS) : 1;
    localparam int OW  = $clog2(TAGS + 1);

    localparam logic [IDW:0]   NUM_REQ  = (IDW + 1)'(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(LEN - 1);
    localparam logic [OW-1:0]  OCC_FULL = OW'(TAGS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Parameter sanity checks at elaboration time.
    if (N < 2) begin : g_bad_n
        $error("replay_seq_arbiter: N must be >= 2");
    end
    if (LEN == 0) begin : g_bad_len
        $error("replay_seq_arbiter: LEN must be >= 1");
    end
    if (TAGS == 0) begin : g_bad_tags
        $error("replay_seq_arbiter: TAGS must be >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      state_reg, state_next;
    logic [IDW-1:0]  sel_reg,   sel_next;
    logic [CW-1:0]   cnt_reg,   cnt_next;
    logic [IDW-1:0]  ptr_reg,   ptr_next;

    logic [IDW-1:0]  tag_mem [TAGS];
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [OW-1:0]   occ_reg,    occ_next;

    logic            busy;
    logic            beat;
    logic            grant;
    logic            fifo_full;
    logic            pop_req;
    logic            pop;

    // ------------------------------------------------------------------
    // Per-requester fan-in/fan-out
    // ------------------------------------------------------------------
    logic [W-1:0] idat_arr [N];

    assign busy = (state_reg == ST_BUSY);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign idat_arr[gi] = idat[gi*W +: W];
            // Only the granted requester can see the buffer's ready.
            assign irdy[gi]     = busy && (sel_reg == IDW'(gi)) && brdy;
        end
    endgenerate

    assign bdat = idat_arr[sel_reg];
    assign bvld = busy && ivld[sel_reg];
    assign beat = bvld && brdy;

    // ------------------------------------------------------------------
    // Round-robin winner: rotate the valid vector so the priority pointer
    // lands at bit 0, then take the lowest set bit. The offset is added
    // back to the pointer modulo N.
    // ------------------------------------------------------------------
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] win_off;
    logic [IDW:0]   win_sum;
    logic [IDW-1:0] win_id;
    logic           win_found;

    assign req_rot = N'({ivld, ivld} >> ptr_reg);

    always_comb begin
        win_off   = '0;
        win_found = |req_rot;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = IDW'(i);
            end
        end
    end

    assign win_sum = {1'b0, ptr_reg} + {1'b0, win_off};
    assign win_id  = (win_sum >= NUM_REQ) ? IDW'(win_sum - NUM_REQ) : win_sum[IDW-1:0];

    // ------------------------------------------------------------------
    // Sequence FSM
    // ------------------------------------------------------------------
    // Fullness uses the registered occupancy: a pop in this cycle does
    // not unblock a grant until the next cycle.
    assign fifo_full = (occ_reg == OCC_FULL);

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        grant      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (win_found && !fifo_full) begin
                    grant      = 1'b1;
                    sel_next   = win_id;
                    ptr_next   = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
                    cnt_next   = '0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAGS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_req = mfin && mvld && mrdy;
    // A pop with nothing stored is a protocol error upstream; drop it.
    assign pop     = pop_req && (occ_reg != '0);

    always_comb begin
        wr_ptr_next = grant ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop   ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        occ_next    = occ_reg;
        if (grant && !pop) begin
            occ_next = occ_reg + 1'b1;
        end else if (!grant && pop) begin
            occ_next = occ_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr_reg] <= win_id;
        end
    end

    assign otag     = tag_mem[rd_ptr_reg];
    assign otag_vld = (occ_reg != '0);

    // Simulation-only protocol check.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pop_req && (occ_reg == '0)))
                else $error("replay_seq_arbiter: tag pop while tag FIFO empty");
        end
    end

endmodule

// File: tb/tb_replay_seq_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for replay_seq_arbiter (N=4, LEN=4, W=8, TAGS=2).
// The stimulus pushes the expected buffer-input beats and tag pops into
// queues. A monitor on the falling edge pops and compares whenever a beat
// (bvld&&brdy) or a tag pop (mfin&&mvld&&mrdy) is presented.
// Requester k produces items {k[1:0], 6'(10 + n)}, where n counts its
// accepted items.
// -----------------------------------------------------------------------------
module tb_replay_seq_arbiter;

    localparam int N    = 4;
    localparam int LEN  = 4;
    localparam int W    = 8;
    localparam int TAGS = 2;
    localparam int IDW  = $clog2(N);

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   idat;
    logic [N-1:0]     ivld;
    logic [N-1:0]     irdy;
    logic [W-1:0]     bdat;
    logic             bvld;
    logic             brdy;
    logic             mfin;
    logic             mvld;
    logic             mrdy;
    logic [IDW-1:0]   otag;
    logic             otag_vld;

    replay_seq_arbiter #(.N(N), .LEN(LEN), .W(W), .TAGS(TAGS)) dut (
        .clk      (clk),
        .rst      (rst),
        .idat     (idat),
        .ivld     (ivld),
        .irdy     (irdy),
        .bdat     (bdat),
        .bvld     (bvld),
        .brdy     (brdy),
        .mfin     (mfin),
        .mvld     (mvld),
        .mrdy     (mrdy),
        .otag     (otag),
        .otag_vld (otag_vld)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int src;
        int data;
    } beat_t;

    beat_t exp_beats [$];
    int    exp_tags  [$];
    int    exp_idx   [N] = '{default: 0};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Requester data model: advance a stream on every accepted item.
    // ------------------------------------------------------------------
    int          dptr [N] = '{default: 0};
    logic [N-1:0] hs = '0;

    always @(negedge clk) hs = ivld & irdy;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) dptr[k]++;
            idat[k*W +: W] = W'((k << 6) | ((10 + dptr[k]) & 63));
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    beat_t mon_e;
    int    mon_t;

    always @(negedge clk) begin
        if (!rst) begin
            if (bvld && brdy) begin
                if (exp_beats.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0d irdy %0d, expected no beat", bdat, irdy);
                end else begin
                    mon_e = exp_beats.pop_front();
                    $display("beat  src=%0d data=%0d", mon_e.src, bdat);
                    chk("beat_data", int'(bdat), mon_e.data);
                    chk("beat_irdy", int'(irdy), 1 << mon_e.src);
                end
            end
            if (mfin && mvld && mrdy) begin
                if (exp_tags.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got otag %0d, expected no pop", otag);
                end else begin
                    mon_t = exp_tags.pop_front();
                    $display("pop   otag=%0d", otag);
                    chk("pop_otag", int'(otag), mon_t);
                    chk("pop_otag_vld", int'(otag_vld), 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic expect_seq(input int k);
        beat_t b;
        for (int i = 0; i < LEN; i++) begin
            b.src  = k;
            b.data = (k << 6) | ((10 + exp_idx[k] + i) & 63);
            exp_beats.push_back(b);
        end
        exp_idx[k] += LEN;
    endtask

    // One cycle: drive inputs just after the rising edge, return at the
    // falling edge so the caller can sample outputs.
    task automatic drive(input logic [N-1:0] v, input logic b, input logic p);
        @(posedge clk);
        #1;
        ivld = v;
        brdy = b;
        mfin = p;
        mvld = p;
        mrdy = p;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ivld = '0;
        brdy = 1'b0;
        mfin = 1'b0;
        mvld = 1'b0;
        mrdy = 1'b0;
        exp_beats.delete();
        exp_tags.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_irdy", int'(irdy), 0);
        chk("rst_bvld", int'(bvld), 0);
        chk("rst_otag_vld", int'(otag_vld), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected end within time limit");
        $fatal(1, "watchdog expired");
    end

    int order [5] = '{0, 1, 2, 3, 0};
    int brdy_pat [6] = '{1, 0, 0, 1, 1, 1};
    int s_save;

    initial begin
        rst  = 1'b1;
        ivld = '0;
        brdy = 1'b0;
        mfin = 1'b0;
        mvld = 1'b0;
        mrdy = 1'b0;
        do_reset();

        // ---- 1: single requester (2) ----
        expect_seq(2);
        exp_tags.push_back(2);
        drive(4'b0100, 1'b1, 1'b0);
        chk("t1_idle_bvld", int'(bvld), 0);
        chk("t1_idle_otag_vld", int'(otag_vld), 0);
        for (int c = 0; c < LEN; c++) begin
            drive(4'b0100, 1'b1, 1'b0);
            chk("t1_bvld", int'(bvld), 1);
            chk("t1_otag", int'(otag), 2);
            chk("t1_otag_vld", int'(otag_vld), 1);
            chk("t1_irdy_others", int'(irdy & 4'b1011), 0);
        end
        drive(4'b0000, 1'b1, 1'b0);
        chk("t1_bubble_bvld", int'(bvld), 0);
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0);
        chk("t1_tag_empty", int'(otag_vld), 0);

        // ---- 2: all valid, round robin, prompt pops ----
        do_reset();
        for (int s = 0; s < 5; s++) begin
            expect_seq(order[s]);
            exp_tags.push_back(order[s]);
            drive(4'b1111, 1'b1, (s > 0));
            chk("t2_bubble_bvld", int'(bvld), 0);
            chk("t2_bubble_irdy", int'(irdy), 0);
            for (int c = 0; c < LEN; c++) begin
                drive(4'b1111, 1'b1, 1'b0);
                chk("t2_bvld", int'(bvld), 1);
                if (c == 0) begin
                    chk("t2_otag_switch", int'(otag), order[s]);
                    chk("t2_otag_vld", int'(otag_vld), 1);
                end
            end
        end
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b0, 1'b0);
        chk("t2_tag_empty", int'(otag_vld), 0);

        // ---- 3: backpressure on requester 1, others valid but ignored ----
        expect_seq(1);
        exp_tags.push_back(1);
        drive(4'b0010, 1'b1, 1'b0);
        chk("t3_idle_bvld", int'(bvld), 0);
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, brdy_pat[i] != 0, 1'b0);
            chk("t3_bvld", int'(bvld), 1);
            chk("t3_irdy", int'(irdy), (brdy_pat[i] != 0) ? 2 : 0);
        end
        drive(4'b0000, 1'b1, 1'b1);
        chk("t3_end_bvld", int'(bvld), 0);
        drive(4'b0000, 1'b0, 1'b0);
        chk("t3_tag_empty", int'(otag_vld), 0);

        // ---- 4: tag FIFO full blocks grants ----
        expect_seq(2);
        expect_seq(3);
        expect_seq(0);
        exp_tags.push_back(2);
        exp_tags.push_back(3);
        exp_tags.push_back(0);
        for (int s = 0; s < 2; s++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk("t4_idle_bvld", int'(bvld), 0);
            for (int c = 0; c < LEN; c++) begin
                drive(4'b1111, 1'b1, 1'b0);
                chk("t4_bvld", int'(bvld), 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk("t4_full_bvld", int'(bvld), 0);
            chk("t4_full_irdy", int'(irdy), 0);
        end
        drive(4'b1111, 1'b1, 1'b1);
        chk("t4_pop_cycle_bvld", int'(bvld), 0);
        drive(4'b1111, 1'b1, 1'b0);
        chk("t4_grant_cycle_bvld", int'(bvld), 0);
        chk("t4_head_after_pop", int'(otag), 3);
        for (int c = 0; c < LEN; c++) begin
            drive(4'b0001, 1'b1, 1'b0);
            chk("t4_regrant_bvld", int'(bvld), 1);
        end
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0);
        chk("t4_tag_empty", int'(otag_vld), 0);

        // ---- 6: reset on the 2nd beat of a sequence ----
        s_save = exp_idx[1];
        expect_seq(1);
        exp_tags.push_back(1);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        chk("t6_first_beat_bvld", int'(bvld), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // The partial sequence is abandoned; requester 1 gave up two items.
        exp_beats.delete();
        exp_tags.delete();
        exp_idx[1] = s_save + 2;
        expect_seq(0);
        exp_tags.push_back(0);
        @(negedge clk);
        chk("t6_post_rst_irdy", int'(irdy), 0);
        chk("t6_post_rst_bvld", int'(bvld), 0);
        chk("t6_post_rst_otag_vld", int'(otag_vld), 0);
        for (int c = 0; c < LEN; c++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk("t6_bvld", int'(bvld), 1);
        end
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b0, 1'b0);
        chk("t6_tag_empty", int'(otag_vld), 0);

        chk("leftover_beats", exp_beats.size(), 0);
        chk("leftover_tags", exp_tags.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
